// File: rtl/pwm_multi.sv
// Multi-channel PWM with one shared period counter and double-buffered TOP/CMP registers.
// Edge- or center-aligned counting; shadows transfer to active registers at each period boundary.
module pwm_multi #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                we,
  input  logic [1:0]          sel,
  input  logic [3:0]          ch,
  input  logic [WIDTH-1:0]    d,
  output logic [CHANNELS-1:0] out,
  output logic [WIDTH-1:0]    cnt,
  output logic                period_end
);

  localparam logic [1:0] SelCmp  = 2'd0;
  localparam logic [1:0] SelTop  = 2'd1;
  localparam logic [1:0] SelCnt  = 2'd2;
  localparam logic [1:0] SelCtrl = 2'd3;

  localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);

  typedef enum logic {DirUp, DirDown} dir_e;

  logic [WIDTH-1:0]    cnt_q, cnt_d;
  dir_e                dir_q, dir_d;
  logic [WIDTH-1:0]    top_act_q, top_act_d;
  logic [WIDTH-1:0]    top_sh_q, top_sh_d;
  logic [WIDTH-1:0]    cmp_act_q [CHANNELS];
  logic [WIDTH-1:0]    cmp_act_d [CHANNELS];
  logic [WIDTH-1:0]    cmp_sh_q  [CHANNELS];
  logic [WIDTH-1:0]    cmp_sh_d  [CHANNELS];
  logic                mode_q, mode_d;
  logic                en_q, en_d;
  logic [CHANNELS-1:0] out_q, out_d;
  logic                pe_q, pe_d;
  logic                load;

  always_comb begin
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    top_act_d = top_act_q;
    top_sh_d  = top_sh_q;
    cmp_act_d = cmp_act_q;
    cmp_sh_d  = cmp_sh_q;
    mode_d    = mode_q;
    en_d      = en_q;
    pe_d      = 1'b0;
    load      = 1'b0;

    if (we && (sel == SelCnt)) begin
      // Direct counter write overrides counting, wrap and shadow load.
      cnt_d = d;
      dir_d = DirUp;
    end else if (en_q) begin
      if (!mode_q) begin
        if (cnt_q >= top_act_q) begin
          cnt_d = '0;
          load  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end else if (dir_q == DirUp) begin
        if ((cnt_q == '0) && (top_act_q == '0)) begin
          load = 1'b1;
        end else if (cnt_q >= top_act_q) begin
          dir_d = DirDown;
          cnt_d = cnt_q - CntOne;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end else begin
        if (cnt_q == '0) begin
          // Bottom of the triangle; a zero TOP keeps the counter parked at 0.
          load  = 1'b1;
          dir_d = DirUp;
          cnt_d = (top_sh_q != '0) ? CntOne : '0;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
    end

    if (load) begin
      pe_d      = 1'b1;
      top_act_d = top_sh_q;
      cmp_act_d = cmp_sh_q;
    end

    if (we && (sel == SelTop)) begin
      top_sh_d = d;
    end
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (we && (sel == SelCmp) && (ch == 4'(i))) begin
        cmp_sh_d[i] = d;
      end
    end
    if (we && (sel == SelCtrl)) begin
      mode_d = d[0];
      en_d   = d[1];
      dir_d  = DirUp;
    end

    for (int unsigned i = 0; i < CHANNELS; i++) begin
      out_d[i] = en_q && (cnt_q < cmp_act_q[i]);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q     <= '0;
      dir_q     <= DirUp;
      top_act_q <= '1;
      top_sh_q  <= '1;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cmp_act_q[i] <= '0;
        cmp_sh_q[i]  <= '0;
      end
      mode_q    <= 1'b0;
      en_q      <= 1'b0;
      out_q     <= '0;
      pe_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      top_act_q <= top_act_d;
      top_sh_q  <= top_sh_d;
      cmp_act_q <= cmp_act_d;
      cmp_sh_q  <= cmp_sh_d;
      mode_q    <= mode_d;
      en_q      <= en_d;
      out_q     <= out_d;
      pe_q      <= pe_d;
    end
  end

  assign out        = out_q;
  assign cnt        = cnt_q;
  assign period_end = pe_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: stimulus pushes expected cnt/out/period_end per cycle,
// a negedge monitor pops and compares.
module tb_pwm_multi;

  localparam int unsigned W = 16;
  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         we = 1'b0;
  logic [1:0]   sel = '0;
  logic [3:0]   ch = '0;
  logic [W-1:0] d = '0;
  logic [N-1:0] out;
  logic [W-1:0] cnt;
  logic         period_end;

  always #5 clk = ~clk;

  pwm_multi #(.WIDTH(W), .CHANNELS(N)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .we         (we),
    .sel        (sel),
    .ch         (ch),
    .d          (d),
    .out        (out),
    .cnt        (cnt),
    .period_end (period_end)
  );

  typedef struct {
    string        name;
    logic [W-1:0] cnt;
    logic [N-1:0] out;
    logic         pe;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if (cnt !== e.cnt) begin
        n_fails++;
        $display("FAIL %s cnt: got %h want %h", e.name, cnt, e.cnt);
      end
      n_checks++;
      if (out !== e.out) begin
        n_fails++;
        $display("FAIL %s out: got %b want %b", e.name, out, e.out);
      end
      n_checks++;
      if (period_end !== e.pe) begin
        n_fails++;
        $display("FAIL %s period_end: got %b want %b", e.name, period_end, e.pe);
      end
    end
  end

  task automatic push(input string n, input logic [W-1:0] c, input logic [N-1:0] o,
                      input logic p);
    exp_t e;
    e.name = n;
    e.cnt  = c;
    e.out  = o;
    e.pe   = p;
    sb.push_back(e);
  endtask

  // Drive one bus cycle; returns 1 time unit after the sampling edge.
  task automatic drive(input logic w, input logic [1:0] s, input logic [3:0] c,
                       input logic [W-1:0] dd);
    we  = w;
    sel = s;
    ch  = c;
    d   = dd;
    @(posedge clk);
    #1;
    we  = 1'b0;
  endtask

  // Edge-mode reference state
  logic [W-1:0] m_cnt, m_top_act, m_top_sh, n_cnt;
  logic [W-1:0] m_cmp_act [N];
  logic [W-1:0] m_cmp_sh  [N];
  logic         m_en, m_pe, n_pe;
  logic [N-1:0] m_out, n_out;

  // Center-mode trace after the post-reset load, rows r17..r35 (hand-derived, TOP=4, CMP0=2)
  int cen_cnt  [19] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3, 4, 3, 2, 1, 0, 1, 2};
  int cen_out0 [19] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
  int cen_pe   [19] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};

  initial begin
    logic         w;
    logic [1:0]   s;
    logic [3:0]   c;
    logic [W-1:0] dd;
    logic [W-1:0] e_cnt;
    logic [N-1:0] e_out;
    logic         e_pe;

    @(posedge clk);
    #1;
    push("reset", '0, '0, 1'b0);
    nrst = 1'b1;

    m_cnt = '0; m_top_act = '1; m_top_sh = '1; m_en = 1'b0; m_pe = 1'b0; m_out = '0;
    for (int i = 0; i < N; i++) begin
      m_cmp_act[i] = '0;
      m_cmp_sh[i]  = '0;
    end

    // Edge mode: setup, first 0xFFFF period, shadow updates, CNT write at wrap,
    // out-of-range channel write, enable freeze/resume.
    for (int k = 1; k <= 96; k++) begin
      w = 1'b0; s = 2'd0; c = 4'd0; dd = '0;
      case (k)
        1:  begin w = 1'b1; s = 2'd1; dd = 16'd9; end
        2:  begin w = 1'b1; s = 2'd0; c = 4'd0; dd = 16'd3; end
        3:  begin w = 1'b1; s = 2'd0; c = 4'd1; dd = 16'd0; end
        4:  begin w = 1'b1; s = 2'd0; c = 4'd2; dd = 16'd10; end
        5:  begin w = 1'b1; s = 2'd3; dd = 16'h0002; end
        6:  begin w = 1'b1; s = 2'd2; dd = 16'hFFFA; end
        16: begin w = 1'b1; s = 2'd0; c = 4'd0; dd = 16'd7; end
        32: begin w = 1'b1; s = 2'd0; c = 4'd0; dd = 16'd5; end
        55: begin w = 1'b1; s = 2'd0; c = 4'd0; dd = 16'd2; end
        62: begin w = 1'b1; s = 2'd2; dd = 16'd5; end
        69: begin w = 1'b1; s = 2'd0; c = 4'd4; dd = 16'd0; end
        80: begin w = 1'b1; s = 2'd3; dd = 16'h0000; end
        85: begin w = 1'b1; s = 2'd3; dd = 16'h0002; end
        default: ;
      endcase

      for (int i = 0; i < N; i++) n_out[i] = m_en && (m_cnt < m_cmp_act[i]);
      if (w && (s == 2'd2)) begin
        n_cnt = dd; n_pe = 1'b0;
      end else if (!m_en) begin
        n_cnt = m_cnt; n_pe = 1'b0;
      end else if (m_cnt >= m_top_act) begin
        n_cnt = '0; n_pe = 1'b1;
        m_top_act = m_top_sh;
        for (int i = 0; i < N; i++) m_cmp_act[i] = m_cmp_sh[i];
      end else begin
        n_cnt = m_cnt + 16'd1; n_pe = 1'b0;
      end
      if (w && (s == 2'd1)) m_top_sh = dd;
      if (w && (s == 2'd0) && (int'(c) < N)) m_cmp_sh[int'(c)] = dd;
      if (w && (s == 2'd3)) m_en = dd[1];
      m_cnt = n_cnt; m_pe = n_pe; m_out = n_out;

      drive(w, s, c, dd);
      push($sformatf("edge k=%0d", k), m_cnt, m_out, m_pe);
    end

    // Asynchronous reset between edges, mid-period with outputs active.
    @(posedge clk);
    #2;
    nrst = 1'b0;
    push("async reset", '0, '0, 1'b0);
    @(posedge clk);
    #1;
    nrst = 1'b1;

    // Post-reset: TOP must be all ones (no wrap at 9, wrap at 0xFFFF), then center mode.
    for (int r = 1; r <= 35; r++) begin
      w = 1'b0; s = 2'd0; c = 4'd0; dd = '0;
      case (r)
        1:  begin w = 1'b1; s = 2'd1; dd = 16'd4; end
        2:  begin w = 1'b1; s = 2'd0; c = 4'd0; dd = 16'd2; end
        3:  begin w = 1'b1; s = 2'd3; dd = 16'h0002; end
        16: begin w = 1'b1; s = 2'd2; dd = 16'hFFFF; end
        18: begin w = 1'b1; s = 2'd3; dd = 16'h0003; end
        default: ;
      endcase
      drive(w, s, c, dd);
      if (r <= 3) begin
        e_cnt = '0; e_out = '0; e_pe = 1'b0;
      end else if (r <= 15) begin
        e_cnt = W'(r - 3); e_out = '0; e_pe = 1'b0;
      end else if (r == 16) begin
        e_cnt = 16'hFFFF; e_out = '0; e_pe = 1'b0;
      end else begin
        e_cnt = W'(cen_cnt[r-17]);
        e_out = (cen_out0[r-17] != 0) ? N'(1) : '0;
        e_pe  = (cen_pe[r-17] != 0);
      end
      push($sformatf("post-reset r=%0d", r), e_cnt, e_out, e_pe);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d failures so far", n_fails);
    $fatal(1);
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Multi-channel PWM generator with one shared period counter and per-channel compare registers. It is the parametrised successor of the single-channel PWM: generalised in width and channel count, with double-buffered (shadow) TOP/CMP registers for glitch-free updates, an edge- or center-aligned mode, an enable, and a period-end strobe. It sits on the peripheral write bus and drives the output pins or gates directly.

Parameters:
WIDTH, 16, counter/compare/top width in bits
CHANNELS, 4, number of PWM outputs (1..16)

Ports:
clk  input  1  system clock, all logic on rising edge
nrst  input  1  asynchronous active-low reset
we  input  1  write strobe, one write per cycle
sel  input  2  target: 0=CMP shadow[ch], 1=TOP shadow, 2=CNT direct, 3=CTRL
ch  input  4  channel index for sel=0
d  input  WIDTH  write data
out  output  CHANNELS  PWM outputs, registered
cnt  output  WIDTH  current counter value
period_end  output  1  one-cycle strobe at period boundary / shadow load

Behaviour:
- Reset: nrst low asynchronously clears cnt=0, dir=up, top_act=top_sh=all ones, cmp_act[i]=cmp_sh[i]=0, mode=0, en=0, out=0, period_end=0.
- CTRL write (sel=3): d[0]=mode (0 edge, 1 center), d[1]=en. Takes effect the next cycle. Writing mode also forces dir=up.
- CMP write with ch >= CHANNELS is ignored. Shadow writes are accepted whether en is 0 or 1.
- en=0: cnt holds its value, out is forced 0, period_end=0, and no shadow load occurs. CNT writes still apply.
- Edge mode with en=1: if cnt >= top_act, then next cnt=0, period_end<=1, top_act<=top_sh, and cmp_act[i]<=cmp_sh[i]. Otherwise cnt<=cnt+1 and period_end<=0.
- Edge mode period is top_act+1 cycles. top_act=0 gives cnt stuck at 0 and period_end every cycle.
- Center mode with en=1: counts up to top_act, flips dir, then counts down to 0.
- Center mode boundary: at cnt==0 while dir=down, dir flips to up, period_end<=1 and the shadow load happens. Cycle sequence is 0,1..T,T-1..1,0,1..., so the period is 2*T cycles (T=top_act). T=0 gives cnt stuck at 0 and period_end every cycle.
- Center mode after a TOP load: if cnt > new top_act while counting up, dir flips to down on the next cycle.
- out[i]<=en & (cnt < cmp_act[i]), evaluated on the registered cnt of the current cycle. So out lags cnt by one cycle.
- Duty extremes: cmp=0 gives constant 0. cmp > top_act gives constant 1.
- Center mode duty: output is symmetric about cnt==T.
- Shadow load vs simultaneous write: the load captures the pre-write shadow value. The new write lands in the shadow and applies at the next boundary.
- CNT write (sel=2) has priority over increment, wrap and direction logic. cnt<=d, dir=up, and no period_end or shadow load in that cycle.
- All arithmetic is unsigned and WIDTH bits. The increment never overflows, because the wrap compare is >=.
- Reset mid-period returns all state to reset values immediately. Outputs are low until en is written again.

Test Plan:
1. Reset, write TOP_sh=9, CMP_sh[0]=3, CMP_sh[1]=0, CMP_sh[2]=10, CTRL=0b10 -> the first period runs to 0xFFFF and then loads. After the load, period is 10 cycles; out[0] high 3 cycles per period, out[1] always 0, out[2] always 1; period_end once per 10 cycles.
2. Mid-period write of CMP_sh[0]=7 -> out[0] duty stays 3/10 until the next period_end, then becomes 7/10. A write coinciding with period_end applies one period later.
3. Center mode: CTRL=0b11, TOP=4, CMP[0]=2 -> cnt sequence 0,1,2,3,4,3,2,1,0; period_end every 8 cycles; out[0] high while cnt<2, symmetric.
4. CNT write d=5 coincident with a wrap in edge mode -> cnt=5 next cycle, no period_end, shadow unchanged; CMP write with ch=CHANNELS -> no register changes.
5. en=0 mid-period -> out=0 and cnt frozen; en=1 -> counting resumes from the frozen value.
6. nrst pulsed low mid-period (async, between clock edges) -> out, cnt and period_end go to 0 immediately; TOP reads back all ones after release.
